// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serializer/deserializer pair.
// Holds the channel count, slot index width and receive FSM states.
package tdm_pkg;

    localparam int TDM_NCH  = 4;
    localparam int TDM_SELW = 2;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Wrapping slot counter for the TDM receiver.
// A frame marker loads 1, because the marker bit itself fills slot 0.
module tdm_slot_cnt
    import tdm_pkg::*;
#(
    parameter int NCH  = TDM_NCH,
    parameter int SELW = TDM_SELW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    output logic [SELW-1:0] sel
);

    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_d;

    // NCH is a power of two, so natural overflow gives the NCH-1 -> 0 wrap.
    always_comb begin
        sel_d = sel_q;
        if (load) begin
            sel_d = SELW'(1);
        end else if (step) begin
            sel_d = sel_q + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel = sel_q;

endmodule

// File: rtl/tdm_demux1x4.sv
// Serial-to-parallel TDM demultiplexer: locks on a frame marker, steers each
// bit to its slot and publishes the completed word with a one-cycle strobe.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HUNT  | unlocked; bits discarded until a frame marker is seen
//   RUN   | locked; each enabled bit fills slot sel, word out at last slot
module tdm_demux1x4
    import tdm_pkg::*;
#(
    parameter int NCH  = TDM_NCH,
    parameter int SELW = TDM_SELW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            din,
    input  logic            frame,
    output logic [NCH-1:0]  dout,
    output logic            valid,
    output logic [SELW-1:0] sel,
    output logic            locked,
    output logic            sync_err
);

    tdm_state_e     state_q;
    tdm_state_e     state_d;
    logic [NCH-1:0] shadow_q;
    logic [NCH-1:0] shadow_d;
    logic [NCH-1:0] dout_q;
    logic [NCH-1:0] dout_d;
    logic [NCH-1:0] word;
    logic           valid_q;
    logic           valid_d;
    logic           sync_err_q;
    logic           sync_err_d;
    logic           cnt_load;
    logic           cnt_step;

    tdm_slot_cnt #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .step  (cnt_step),
        .sel   (sel)
    );

    // The last slot's bit goes straight into dout, never via the shadow flops.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        word       = shadow_q;
        word[sel]  = din;

        if (en) begin
            if (frame) begin
                cnt_load    = 1'b1;
                shadow_d    = '0;
                shadow_d[0] = din;
                state_d     = RUN;
                if (state_q == RUN && sel != '0) begin
                    sync_err_d = 1'b1;
                end
            end else if (state_q == RUN) begin
                cnt_step = 1'b1;
                shadow_d = word;
                if (sel == SELW'(NCH - 1)) begin
                    dout_d  = word;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign dout     = dout_q;
    assign valid    = valid_q;
    assign sync_err = sync_err_q;
    assign locked   = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Self-checking bench for tdm_demux1x4: directed scenarios plus random traffic,
// compared against a queue-based frame model.
module tb_tdm_demux1x4;
    import tdm_pkg::*;

    localparam int NCH  = TDM_NCH;
    localparam int SELW = TDM_SELW;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            din;
    logic            frame;
    logic [NCH-1:0]  dout;
    logic            valid;
    logic [SELW-1:0] sel;
    logic            locked;
    logic            sync_err;

    int n_checks;
    int n_pass;

    // Reference model: collected bits of the frame in progress.
    bit             m_locked;
    bit             m_bits[$];
    logic [NCH-1:0] exp_dout;
    logic           exp_valid;
    logic           exp_serr;

    tdm_demux1x4 #(.NCH(NCH), .SELW(SELW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .frame    (frame),
        .dout     (dout),
        .valid    (valid),
        .sel      (sel),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked  = 1'b0;
        m_bits.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_serr  = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic f, input logic d);
        logic [NCH-1:0] w;
        exp_valid = 1'b0;
        exp_serr  = 1'b0;
        if (e) begin
            if (f) begin
                if (m_locked && m_bits.size() != 0) exp_serr = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                m_bits.push_back(d);
                if (m_bits.size() == NCH) begin
                    for (int i = 0; i < NCH; i++) w[i] = m_bits[i];
                    exp_dout  = w;
                    exp_valid = 1'b1;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("dout",     32'(dout),     32'(exp_dout));
        chk("valid",    32'(valid),    32'(exp_valid));
        chk("sel",      32'(sel),      32'(m_bits.size()));
        chk("locked",   32'(locked),   32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(exp_serr));
        chk("excl",     32'(valid & sync_err), 32'd0);
    endtask

    task automatic step(input logic e, input logic f, input logic d);
        @(negedge clk);
        en    = e;
        frame = f;
        din   = d;
        @(posedge clk);
        model_step(e, f, d);
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [NCH-1:0] w, input logic marker);
        for (int k = 0; k < NCH; k++) step(1'b1, marker && (k == 0), w[k]);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        en       = 1'b0;
        din      = 1'b0;
        frame    = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then lock: noise is ignored, first word 0001.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom_range(1)));
        chk("hunt_locked", 32'(locked), 32'd0);
        send_word(4'b0001, 1'b1);
        chk("lock_word", 32'(dout), 32'h1);
        chk("lock_valid", 32'(valid), 32'd1);

        // Back-to-back frames.
        send_word(4'b1000, 1'b1);
        chk("b2b_0", 32'(dout), 32'h8);
        send_word(4'b1110, 1'b1);
        chk("b2b_1", 32'(dout), 32'he);
        send_word(4'b0101, 1'b1);
        chk("b2b_2", 32'(dout), 32'h5);

        // Early marker after slots 0,1.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("early_serr", 32'(sync_err), 32'd1);
        chk("early_dout", 32'(dout), 32'h5);
        chk("early_sel", 32'(sel), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("early_word", 32'(dout), 32'h5);
        chk("early_valid", 32'(valid), 32'd1);

        // Enable stall between slots 1 and 2 of 1011.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            chk("stall_sel", 32'(sel), 32'd2);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("stall_word", 32'(dout), 32'hb);

        // Async reset mid-frame at sel=2.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom_range(1)));
        chk("arst_ignored", 32'(locked), 32'd0);

        // Markerless continuation after lock.
        send_word(4'b1001, 1'b1);
        send_word(4'b0010, 1'b0);
        chk("free_0", 32'(dout), 32'h2);
        send_word(4'b0110, 1'b0);
        chk("free_1", 32'(dout), 32'h6);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(9) != 0), 1'($urandom_range(6) == 0), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux1x4.md
# tdm_demux1x4

Sequential 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the 4:1 mux: a serial bit stream carries the four channel bits in slot order 0..3. The block locks onto a frame marker, steps a slot counter and steers each bit to its channel, then presents the completed 4-bit word with a one-cycle valid strobe. It sits between the serial link and the 4-bit parallel consumers that originally fed `mux4x1`.

## Interface
- `NCH`, default 4: number of channels (slots per frame). Must be a power of 2 and at least 2.
- `SELW`, default 2: slot index width, equal to clog2(`NCH`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample enable; when 0, din/frame are ignored and all state holds.
- `din`  in  1  serial data bit for the current slot.
- `frame`  in  1  frame marker; high with the slot-0 bit.
- `dout`  out  `NCH`  last completed word; `dout[k]` holds slot k.
- `valid`  out  1  one-cycle strobe; `dout` was updated on this edge.
- `sel`  out  `SELW`  slot index the next sampled bit will be written to.
- `locked`  out  1  1 while in RUN.
- `sync_err`  out  1  one-cycle pulse; `frame` arrived at a slot other than 0.

## Operation
- Reset state:
  - dout=0, valid=0, sel=0, locked=0, sync_err=0.
  - Shadow register = 0; FSM = HUNT.
- FSM states: HUNT, RUN.
- HUNT:
  - Bits with frame=0 are discarded.
  - On en=1 & frame=1: shadow[0]=din, sel←1, go to RUN.
- RUN, each en=1 edge:
  - frame=0: shadow[sel]=din; sel←sel+1 (wraps `NCH`-1 → 0).
  - When sel=`NCH`-1 is written: dout←{din, shadow[`NCH`-2:0]} and valid=1 on that edge. The completed word is never delayed by the shadow register.
  - frame=1 with sel=0: normal frame start. shadow[0]=din, sel←1.
  - frame=1 with sel≠0 (early marker):
    - Partial word discarded; shadow cleared.
    - shadow[0]=din, sel←1; stay in RUN.
    - sync_err=1 for one cycle; dout unchanged; valid=0.
  - frame=0 at sel=0 is legal (free-running continuation). Frames need not carry markers after lock.
- en=0: no state change; valid and sync_err are forced 0 for that cycle.
- Reset mid-frame returns to HUNT immediately. Partial word is lost; dout clears to 0.

## Timing
- Latency: the slot-3 bit sampled at edge N appears on dout[3] after edge N, with valid high during cycle N→N+1.
- First valid comes `NCH` enabled cycles after the marker cycle, counting the marker cycle.
- Throughput: one word per `NCH` enabled cycles; back-to-back frames have no gaps.
- All outputs are registered; no combinational path from inputs to outputs.
- valid and sync_err are never high in the same cycle.

## Structure
- Shared package `tdm_pkg` holds:
  - FSM state typedef {HUNT, RUN}.
  - Constants `TDM_NCH`=4 and `TDM_SELW`=2, also used by the serializer side.
- Optional sub-module `tdm_slot_cnt`: the wrapping slot counter with load-to-1 on marker.
- FSM, shadow register and output registers stay in the top.
- Target size is about 150 lines of RTL.

## Test plan
- Reset then lock:
  - Stimulus: rst_n=0 for 2 cycles, release; 3 cycles of noise with frame=0; then frame=1 with din slots 0..3 = 1,0,0,0.
  - Required: locked=0 until the marker edge and 1 after; dout=4'b0001 with valid after the 4th bit; sync_err never asserts.
- Back-to-back frames:
  - Stimulus: words 4'b1000, 4'b1110, 4'b0101, each with frame on slot 0.
  - Required: valid every 4th cycle; dout takes those values in order; sel cycles 1,2,3,0.
- Early marker:
  - Stimulus: after slots 0,1 of a frame, assert frame with din=1.
  - Required: sync_err one cycle; dout keeps its previous value; sel=1; next completed word built from the new frame only.
- Enable stall:
  - Stimulus: hold en=0 for 3 cycles between slots 1 and 2 of word 4'b1011.
  - Required: sel frozen during the stall; no valid during the stall; dout=4'b1011 after the remaining slots.
- Async reset mid-frame:
  - Stimulus: drop rst_n between clock edges at sel=2.
  - Required: dout=0, sel=0, locked=0 immediately, without waiting for an edge; subsequent bits ignored until the next frame=1.
- Markerless continuation:
  - Stimulus: after lock, send words 4'b0010 and 4'b0110 with frame=0 throughout.
  - Required: both words delivered with valid; no sync_err.
